// File: rtl/mem_req_scheduler_pkg.sv
// Shared memory request/response types and scheduler sizing helpers.
package ShellTypes;
  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } MemReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } MemResp;
endpackage

package mem_sched_pkg;
  localparam int DEFAULT_NUM_APPS = 2;
  localparam int APP_ID_W = $clog2(DEFAULT_NUM_APPS);

  function automatic int id_width(input int num_apps);
    return (num_apps > 1) ? $clog2(num_apps) : 1;
  endfunction

  // Width of a counter that must represent 0..max_cnt inclusive.
  function automatic int cnt_width(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction
endpackage

// File: rtl/mem_req_scheduler_if.sv
// App-side and memory-side handshake bundle for mem_req_scheduler.
interface mem_req_scheduler_if
  import ShellTypes::*;
#(
  parameter int NUM_APPS = 2
);
  MemReq               app_reqs [NUM_APPS];
  logic [NUM_APPS-1:0] app_req_grants;
  MemResp              app_resps [NUM_APPS];
  logic [NUM_APPS-1:0] app_resp_grants;
  MemReq               mem_req;
  logic                mem_req_grant;
  MemResp              mem_resp;
  logic                mem_resp_grant;

  // master is the scheduler's view; slave is the apps plus memory port.
  modport master (
    input  app_reqs, app_resp_grants, mem_req_grant, mem_resp,
    output app_req_grants, app_resps, mem_req, mem_resp_grant
  );
  modport slave (
    output app_reqs, app_resp_grants, mem_req_grant, mem_resp,
    input  app_req_grants, app_resps, mem_req, mem_resp_grant
  );
endinterface

// File: rtl/mem_req_scheduler_fifo.sv
// Show-ahead FIFO used as the in-order tag queue; push and pop may coincide even when full.
module FIFO #(
  parameter int WIDTH     = 1,
  parameter int LOG_DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem_reg [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LOG_DEPTH:0]   count_reg;
  logic                 do_wr, do_rd;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_CNT);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) mem_reg[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_wr && !do_rd)      count_reg <= count_reg + 1'b1;
      else if (do_rd && !do_wr) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

// File: rtl/mem_req_scheduler.sv
// Round-robin sharing of one memory port across NUM_APPS with per-app read credits.
// Optional weighted turns when MEM_SCHED_WEIGHTED_EN is defined.
module mem_req_scheduler
  import ShellTypes::*, mem_sched_pkg::*;
#(
  parameter int NUM_APPS        = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_LOG_DEPTH   = 5,
  parameter int WEIGHT_WIDTH    = 4
) (
  input  logic clk,
  input  logic rst,
  mem_req_scheduler_if.master bus,
`ifdef MEM_SCHED_WEIGHTED_EN
  input  logic [NUM_APPS-1:0][WEIGHT_WIDTH-1:0] weights,
`endif
  output logic [NUM_APPS-1:0][cnt_width(MAX_OUTSTANDING)-1:0] outstanding,
  output logic protocol_err
);
  localparam int ID_W  = id_width(NUM_APPS);
  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [ID_W-1:0]                 ptr_reg, ptr_next, sel, sel_succ, cand, head;
  logic [NUM_APPS-1:0]             elig;
  logic [NUM_APPS-1:0][CNT_W-1:0]  cnt_reg, cnt_next;
  logic any_elig, grant, tag_push, tag_pop, tag_full, tag_empty, resp_ok;
  logic rst_d_reg, blank, err_reg, err_next;
`ifdef MEM_SCHED_WEIGHTED_EN
  logic [WEIGHT_WIDTH-1:0] burst_reg, burst_next;
`else
  localparam int unused_weight_width = WEIGHT_WIDTH;
`endif

  // Outputs stay quiet during reset and for one cycle after it.
  assign blank = rst || rst_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_APPS; gi++) begin : g_app
      logic inc, dec;
      assign elig[gi] = !blank && bus.app_reqs[gi].valid &&
                        (bus.app_reqs[gi].isWrite || (cnt_reg[gi] < CNT_MAX && !tag_full));
      assign inc = tag_push && (sel == ID_W'(gi));
      assign dec = tag_pop && (head == ID_W'(gi));
      assign cnt_next[gi] = (inc && !dec) ? cnt_reg[gi] + 1'b1 :
                            (dec && !inc) ? cnt_reg[gi] - 1'b1 : cnt_reg[gi];
      assign bus.app_resps[gi] = '{valid: resp_ok && (head == ID_W'(gi)),
                                   data:  bus.mem_resp.data};
    end
  endgenerate

  always_comb begin
    // Descending scan so the last hit is the nearest eligible app at or after ptr.
    sel      = ptr_reg;
    cand     = '0;
    any_elig = 1'b0;
    for (int k = NUM_APPS - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr_reg) + k) % NUM_APPS);
      if (elig[cand]) begin
        sel      = cand;
        any_elig = 1'b1;
      end
    end

    bus.mem_req = '0;
    if (any_elig) begin
      bus.mem_req       = bus.app_reqs[sel];
      bus.mem_req.valid = 1'b1;
    end
    grant              = any_elig && bus.mem_req_grant;
    bus.app_req_grants = '0;
    if (grant) bus.app_req_grants[sel] = 1'b1;
    tag_push = grant && !bus.app_reqs[sel].isWrite;

    sel_succ = (sel == ID_W'(NUM_APPS - 1)) ? '0 : sel + 1'b1;
    ptr_next = ptr_reg;
`ifdef MEM_SCHED_WEIGHTED_EN
    burst_next = elig[ptr_reg] ? burst_reg : '0;
    if (grant) begin
      if (sel == ptr_reg && burst_reg < weights[ptr_reg]) begin
        burst_next = burst_reg + 1'b1;
      end else begin
        ptr_next   = sel_succ;
        burst_next = '0;
      end
    end
`else
    if (grant) ptr_next = sel_succ;
`endif

    resp_ok            = !blank && bus.mem_resp.valid && !tag_empty;
    bus.mem_resp_grant = resp_ok && bus.app_resp_grants[head];
    tag_pop            = bus.mem_resp_grant;
    err_next           = err_reg || (bus.mem_resp.valid && tag_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_d_reg <= 1'b1;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
`ifdef MEM_SCHED_WEIGHTED_EN
      burst_reg <= '0;
`endif
    end else begin
      rst_d_reg <= 1'b0;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
`ifdef MEM_SCHED_WEIGHTED_EN
      burst_reg <= burst_next;
`endif
    end
  end

  assign outstanding  = cnt_reg;
  assign protocol_err = err_reg;

  FIFO #(
    .WIDTH     (ID_W),
    .LOG_DEPTH (TAG_LOG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_push),
    .wr_data (sel),
    .rd_en   (tag_pop),
    .rd_data (head),
    .full    (tag_full),
    .empty   (tag_empty)
  );
endmodule

// File: doc/mem_req_scheduler.md
# mem_req_scheduler

Shares one physical memory port between `NUM_APPS` application request streams. It sits in front of the MMU's per-app request inputs, or directly in front of the DRAM shell port. Arbitration is round-robin, optionally weighted, and each app has a cap on outstanding reads. Read responses return in order and are steered back to the issuing app using an in-order app-ID tag queue.

## Interface
- `NUM_APPS`, 2: number of requesters, ≥2.
- `MAX_OUTSTANDING`, 8: per-app cap on in-flight reads, ≥1.
- `TAG_LOG_DEPTH`, 5: log2 depth of the tag queue.
- `WEIGHT_WIDTH`, 4: width of each weight field (used only when weighting is compiled in).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `app_reqs` in `MemReq[NUM_APPS]`: app requests, qualified by `.valid`.
- `app_req_grants` out 1×`NUM_APPS`: request accepted this cycle.
- `app_resps` out `MemResp[NUM_APPS]`: routed read responses.
- `app_resp_grants` in 1×`NUM_APPS`: app consumes its response.
- `mem_req` out `MemReq`: request to the shared port.
- `mem_req_grant` in 1: port accepts `mem_req` this cycle.
- `mem_resp` in `MemResp`: read response from the port, in issue order.
- `mem_resp_grant` out 1: response consumed.
- `weights` in `WEIGHT_WIDTH`×`NUM_APPS`: grants per turn minus 1. Present only with `MEM_SCHED_WEIGHTED_EN`.
- `outstanding` out `$clog2(MAX_OUTSTANDING+1)`×`NUM_APPS`: per-app credit counters.
- `protocol_err` out 1: sticky flag, set when a response arrives with no tag queued.

## Operation
- **Eligibility.** `elig[i]` = `app_reqs[i].valid` & (`isWrite` | (`outstanding[i]` < `MAX_OUTSTANDING` & !`tag_full`)).
  - Writes never produce a response and consume no credit or tag.
- **Selection.**
  - `sel` is the first eligible app at or after pointer `ptr`, searching cyclically.
  - `mem_req` = `app_reqs[sel]`, with `.valid` = OR of all `elig`.
  - When no app is eligible, `mem_req` = `'0`.
- **Request grant.** `app_req_grants[sel]` = `mem_req.valid` & `mem_req_grant`. All other grants are 0.
- **Read issue.** On a granted read: push `sel` into the tag queue and increment `outstanding[sel]`.
- **Pointer, unweighted.** On any grant, `ptr` ← (`sel`+1) mod `NUM_APPS`.
- **Response routing.** `head` = the tag queue output.
  - `app_resps[head].valid` = `mem_resp.valid` & !`tag_empty`. `.data` passes through to every app. Other apps' valid = 0.
  - `mem_resp_grant` = `mem_resp.valid` & !`tag_empty` & `app_resp_grants[head]`.
  - On the handshake: pop the tag and decrement `outstanding[head]`.
- **Simultaneous events.**
  - Issue and retire for the same app in one cycle: counter unchanged.
  - Push and pop on the tag queue in one cycle are both legal, including when the queue is full. Eligibility uses the registered `tag_full`, so no bypass is needed.
- **Orphan response.** `mem_resp.valid` while `tag_empty`: `mem_resp_grant` = 0, `protocol_err` ← 1. It clears only on `rst`.
- **Counter safety.** Counters never wrap. Decrement at 0 cannot occur, because the tag queue guards it.

## Timing
- Request path is combinational: 0-cycle latency from `app_reqs` to `mem_req`, and from `mem_req_grant` to `app_req_grants`.
- Response path is combinational: 0 cycles from `mem_resp` to `app_resps`.
- State (`ptr`, burst counter, `outstanding`, tag queue, `protocol_err`) updates on the `clk` edge after the handshake.
- **Reset.** While `rst` is high, and on the first cycle after, all grants and valids are 0. After reset: `ptr` = 0, `outstanding` = 0, tag queue empty, `protocol_err` = 0.
- **Reset mid-operation.** In-flight reads are forgotten. Late responses after reset raise `protocol_err`; the integrator must reset the memory side together with this block.
- An app with `valid` held high and no grant must keep its request stable, matching the shell handshake rule.

## Configuration
- **`MEM_SCHED_WEIGHTED_EN` defined:**
  - The `weights` port exists. A `burst` counter tracks grants within the current turn.
  - On a grant to `sel`: if `sel` == `ptr` and `burst` < `weights[ptr]`, then `burst`++ and `ptr` holds. Otherwise `ptr` ← (`sel`+1) mod `NUM_APPS` and `burst` ← 0.
  - If app `ptr` is not eligible in a cycle, `burst` ← 0.
- **Not defined:** the `weights` port and burst counter are absent; plain round-robin as in Operation.

## Structure
- `MemReq` and `MemResp` come from `ShellTypes`.
- A new package `mem_sched_pkg` holds `APP_ID_W` = `$clog2(NUM_APPS)` default and the counter-width helper.
- The tag queue is the existing `FIFO` module, `WIDTH`=`APP_ID_W`, `LOG_DEPTH`=`TAG_LOG_DEPTH`. It is the only sub-module.
- Arbitration, credits and routing live in one always/assign body.

## Test plan
- **RR fairness.** Apps 0 and 1 both hold reads, `mem_req_grant`=1 constantly → grants alternate 0,1,0,1. The tag queue holds 0,1,0,1.
- **Credit cap.** `MAX_OUTSTANDING`=2, app 0 issues 3 reads with no responses → third not granted, `outstanding[0]`=2. One response retires → grant the next cycle.
- **Response routing.** Issue read app1 then app0. Return responses D1, D0 → `app_resps[1]` gets D1 first, then `app_resps[0]` gets D0. Both counters return to 0.
- **Backpressure.** `app_resp_grants[head]`=0 for 5 cycles → `mem_resp_grant`=0, nothing pops, no data loss.
- **Weighted.** With `MEM_SCHED_WEIGHTED_EN`, `weights`={0,2} (app1=2) → grant order 0,1,1,1,0,1,1,1.
- **Orphan and reset.** Response with an empty tag queue → `protocol_err`=1 and stays set. Assert `rst` with 3 reads outstanding → all counters are 0 and `protocol_err`=0 the next cycle.
